// File: rtl/mac_pkg.sv
// Shared widths and operand/accumulator types for the Vedic multiply-accumulate unit.
package mac_pkg;
    localparam int MAC_WIDTH = 64;
    localparam int MAC_ACC_W = 2 * MAC_WIDTH;

    typedef logic [MAC_WIDTH-1:0] operand_t;
    typedef logic [MAC_ACC_W-1:0] acc_t;
endpackage

// File: rtl/vedic_mul64.sv
// Combinational Urdhva-Tiryagbhyam multiplier: each NxN node splits into four (N/2)x(N/2)
// nodes, recursing down to a 2x2 leaf of AND gates and half-adders.
module vedic_mul_node #(
    parameter int N = 64
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);
    localparam int H = N / 2;

    generate
        if (N == 2) begin : g_leaf
            logic c1;
            logic s1;
            assign s1 = (a[1] & b[0]) ^ (a[0] & b[1]);
            assign c1 = (a[1] & b[0]) & (a[0] & b[1]);
            assign p[0] = a[0] & b[0];
            assign p[1] = s1;
            assign p[2] = (a[1] & b[1]) ^ c1;
            assign p[3] = (a[1] & b[1]) & c1;
        end else begin : g_node
            logic [N-1:0]   pp_ll;
            logic [N-1:0]   pp_lh;
            logic [N-1:0]   pp_hl;
            logic [N-1:0]   pp_hh;
            logic [N:0]     mid;
            logic [2*N-1:0] mid_ext;

            vedic_mul_node #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(pp_ll));
            vedic_mul_node #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(pp_lh));
            vedic_mul_node #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(pp_hl));
            vedic_mul_node #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(pp_hh));

            // Cross products share the N/2 offset, so sum them first (keeping the carry).
            assign mid     = {1'b0, pp_lh} + {1'b0, pp_hl};
            assign mid_ext = {{(H-1){1'b0}}, mid, {H{1'b0}}};
            assign p       = {pp_hh, pp_ll} + mid_ext;
        end
    endgenerate
endmodule

module vedic_mul64 #(
    parameter int WIDTH = mac_pkg::MAC_WIDTH
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);
    vedic_mul_node #(.N(WIDTH)) u_root (.a(a), .b(b), .p(p));
endmodule

// File: rtl/vedic_mac64.sv
// 64x64 unsigned multiply-accumulate: combinational Vedic product added into a
// 128-bit wrapping accumulator on every enabled clock edge.
module vedic_mac64
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 enable,
    output logic [2*WIDTH-1:0]   acc
);
    localparam int ACC_W = 2 * WIDTH;

    logic [ACC_W-1:0] product;

    vedic_mul64 #(.WIDTH(WIDTH)) u_mul (
        .a (a),
        .b (b),
        .p (product)
    );

    // rst is active-low and asynchronous; the sum wraps modulo 2^ACC_W by construction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + product;
        end
    end
endmodule

// File: tb/tb_vedic_mac64.sv
// Directed and randomised checks of vedic_mac64 against hand-computed values and a 128-bit model.
module tb_vedic_mac64;
    logic         clk;
    logic         rst;
    logic [63:0]  a;
    logic [63:0]  b;
    logic         enable;
    logic [127:0] acc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] exp_q[$];
    logic [127:0] model_acc;

    vedic_mac64 dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .enable (enable),
        .acc    (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%032h expected 0x%032h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after a rising edge; outputs are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mac(input logic [63:0] x, input logic [63:0] y, input logic en);
        a      = x;
        b      = y;
        enable = en;
        step();
    endtask

    task automatic reset_pulse(input string tag);
        rst = 1'b0;
        #2;
        check(tag, acc, 128'd0);
        rst = 1'b1;
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic        ren;

        rst    = 1'b0;
        a      = '0;
        b      = '0;
        enable = 1'b0;
        #3;
        check("reset_no_clock", acc, 128'd0);

        // Reset must dominate enable across an edge.
        a      = 64'd7;
        b      = 64'd9;
        enable = 1'b1;
        step();
        check("reset_dominates", acc, 128'd0);
        enable = 1'b0;
        rst    = 1'b1;
        step();
        check("release_idle", acc, 128'd0);

        mac(64'd2, 64'd3, 1'b1);
        check("acc_2x3", acc, 128'd6);
        mac(64'd4, 64'd5, 1'b1);
        check("acc_4x5", acc, 128'd26);
        mac(64'd8, 64'd67, 1'b1);
        check("acc_8x67", acc, 128'd562);
        mac(64'd10, 64'd10, 1'b0);
        check("hold", acc, 128'd562);
        mac(64'd16, 64'd16, 1'b1);
        check("acc_16x16", acc, 128'd818);

        reset_pulse("midrun_reset");
        mac(64'd255, 64'd255, 1'b1);
        check("level_1", acc, 128'd65025);
        step();
        check("level_2", acc, 128'd130050);

        reset_pulse("wrap_reset");
        mac(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        check("wrap_1", acc, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        step();
        check("wrap_2", acc, 128'hFFFF_FFFF_FFFF_FFFC_0000_0000_0000_0002);

        // Cross-half operands exercise every partial-product path.
        reset_pulse("cross_reset");
        mac(64'h0000_0001_0000_0000, 64'h0000_0000_0000_0003, 1'b1);
        check("cross_hi_lo", acc, 128'h0000_0000_0000_0000_0000_0003_0000_0000);
        mac(64'h8000_0000_0000_0000, 64'h0000_0000_0000_0002, 1'b1);
        check("cross_msb", acc, 128'h0000_0000_0000_0001_0000_0003_0000_0000);

        reset_pulse("random_reset");
        model_acc = '0;
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 7))
                0:       ra = 64'hFFFF_FFFF_FFFF_FFFF;
                1:       ra = {32'd0, $urandom};
                default: ra = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 64'hFFFF_FFFF_FFFF_FFFF;
                1:       rb = {$urandom, 32'd0};
                default: rb = {$urandom, $urandom};
            endcase
            ren = ($urandom_range(0, 3) != 0);
            if (ren) model_acc = model_acc + ({64'd0, ra} * {64'd0, rb});
            exp_q.push_back(model_acc);
            mac(ra, rb, ren);
            check("random", acc, exp_q.pop_front());
            if ($urandom_range(0, 49) == 0) begin
                reset_pulse("random_async_reset");
                model_acc = '0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: simulation did not complete within 200000ns");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
